ps2_key_cmd: RTL and testbench
==============================

Name: ps2_key_cmd

Overview:
- Consumes decoded PS2 key events (`{expand, break, scancode}` plus a one-cycle valid strobe) from the PS2 receiver stage.
- Maps the game keys (arrows, WASD, R, Esc) to move/restart commands and suppresses typematic auto-repeat.
- Queues commands in a small FIFO and hands them to the game FSM over a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, FIFO pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- key_data  in  10  bit9 expand (E0 prefix), bit8 break (F0 prefix), bits7:0 scancode
- key_valid  in  1  one-cycle strobe; key_data valid in this cycle
- cmd  out  3  head-of-FIFO command: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 RESTART
- cmd_valid  out  1  FIFO non-empty
- cmd_ready  in  1  consumer accepts head when cmd_valid && cmd_ready at clk rising edge
- held  out  10  per-physical-key pressed flags (index order listed below)
- overflow  out  1  sticky; set when a command is dropped because the FIFO is full
- clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - FIFO empty; cmd_valid=0; cmd=0.
  - held=0; overflow=0.
  - Pointers and count = 0.
- Key table (held index: key, expand, scancode -> cmd):
  - 0: Up arrow, 1, 75 -> UP
  - 1: Down arrow, 1, 72 -> DOWN
  - 2: Left arrow, 1, 6B -> LEFT
  - 3: Right arrow, 1, 74 -> RIGHT
  - 4: W, 0, 1D -> UP
  - 5: S, 0, 1B -> DOWN
  - 6: A, 0, 1C -> LEFT
  - 7: D, 0, 23 -> RIGHT
  - 8: R, 0, 2D -> RESTART
  - 9: Esc, 0, 76 -> RESTART
- Matching uses both expand and scancode: 75 without E0 (keypad 8) does not match. Unmatched codes are ignored entirely.
- Make event on a matched key (key_valid=1, break=0):
  - If held[i]=0: set held[i], push the command.
  - If held[i]=1 (typematic repeat): no push, held unchanged.
- Break event on a matched key (break=1): clear held[i], no push.
- Push timing: key_valid sampled at edge N -> entry written at edge N. cmd_valid=1 and cmd updated in cycle N+1. Total latency is 1 clk.
- Pop: cmd_valid && cmd_ready at an edge advances the read pointer. cmd and cmd_valid are driven from registered FIFO state, with no combinational path from cmd_ready.
- Full (count==DEPTH):
  - Push is accepted only if a pop occurs in the same edge; count is then unchanged.
  - Otherwise the command is dropped and overflow is set.
  - held[i] is still set on a dropped make, so a held key cannot re-fire.
- Empty: cmd_ready is ignored; a simultaneous push and pop on empty is impossible because cmd_valid=0, so it is a push only.
- Pointers wrap modulo DEPTH. count has width AW+1.
- clr_overflow and an overflow event in the same cycle: set wins.
- Independent keys queue in press order. Example: Up then A while Up is held -> UP, LEFT.
- rst mid-operation: FIFO flushed, held cleared. A key physically held across reset re-fires on its next typematic make; this is accepted behaviour.

Test Plan:
- Reset, then key_valid with {1,0,75} -> next cycle cmd_valid=1, cmd=0, held[0]=1; pulse cmd_ready -> cmd_valid=0.
- {0,0,1D} three times (typematic), then {0,1,1D}, then {0,0,1D} -> exactly two UP commands queued; held[4] ends at 1.
- {0,0,75} (no E0) and {0,0,5A} (Enter) -> no push; held and cmd_valid stay 0.
- cmd_ready=0; five distinct makes (Up, Down, Left, Right, R) -> FIFO holds 0,1,2,3 and overflow=1. Drain -> order 0,1,2,3. Pulse clr_overflow -> overflow=0.
- FIFO full with cmd_ready=1 and a new make (Esc) in the same cycle -> push accepted, count stays 4, overflow stays 0, tail=4.
- Assert rst with FIFO at 2 entries and held=0x011 -> cmd_valid=0, held=0, overflow=0 immediately; the first command after release is delivered normally.

Source files
------------

// File: rtl/ps2_key_cmd.sv
// Turns decoded PS2 key events into game move/restart commands, filtering typematic
// auto-repeat, and queues them in a small FIFO read through a valid/ready handshake.
module ps2_key_cmd #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] key_data,
    input  logic       key_valid,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [9:0] held,
    output logic       overflow,
    input  logic       clr_overflow
);

    localparam logic [2:0]  CMD_UP      = 3'd0;
    localparam logic [2:0]  CMD_DOWN    = 3'd1;
    localparam logic [2:0]  CMD_LEFT    = 3'd2;
    localparam logic [2:0]  CMD_RIGHT   = 3'd3;
    localparam logic [2:0]  CMD_RESTART = 3'd4;
    localparam logic [AW:0] FULL_CNT    = (AW+1)'(DEPTH);

    logic [9:0]    keySel;
    logic [2:0]    keyCmd;
    logic          makeEvt;
    logic          breakEvt;
    logic          pushReq;
    logic          pushEn;
    logic          popEn;
    logic          fifoFull;
    logic          dropEvt;

    logic [9:0]    held_q, held_d;
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [2:0]    mem_q [DEPTH];

    // Match on expand flag and scancode together so keypad codes without E0 are ignored.
    always_comb begin
        keySel = 10'd0;
        keyCmd = CMD_UP;
        case ({key_data[9], key_data[7:0]})
            {1'b1, 8'h75}: begin keySel = 10'b00_0000_0001; keyCmd = CMD_UP;      end
            {1'b1, 8'h72}: begin keySel = 10'b00_0000_0010; keyCmd = CMD_DOWN;    end
            {1'b1, 8'h6B}: begin keySel = 10'b00_0000_0100; keyCmd = CMD_LEFT;    end
            {1'b1, 8'h74}: begin keySel = 10'b00_0000_1000; keyCmd = CMD_RIGHT;   end
            {1'b0, 8'h1D}: begin keySel = 10'b00_0001_0000; keyCmd = CMD_UP;      end
            {1'b0, 8'h1B}: begin keySel = 10'b00_0010_0000; keyCmd = CMD_DOWN;    end
            {1'b0, 8'h1C}: begin keySel = 10'b00_0100_0000; keyCmd = CMD_LEFT;    end
            {1'b0, 8'h23}: begin keySel = 10'b00_1000_0000; keyCmd = CMD_RIGHT;   end
            {1'b0, 8'h2D}: begin keySel = 10'b01_0000_0000; keyCmd = CMD_RESTART; end
            {1'b0, 8'h76}: begin keySel = 10'b10_0000_0000; keyCmd = CMD_RESTART; end
            default:       begin keySel = 10'd0;            keyCmd = CMD_UP;      end
        endcase
    end

    always_comb begin
        makeEvt  = key_valid && (keySel != 10'd0) && !key_data[8];
        breakEvt = key_valid && (keySel != 10'd0) &&  key_data[8];
        pushReq  = makeEvt && ((held_q & keySel) == 10'd0);

        fifoFull = (count_q == FULL_CNT);
        popEn    = (count_q != '0) && cmd_ready;
        pushEn   = pushReq && (!fifoFull || popEn);
        dropEvt  = pushReq && fifoFull && !popEn;
    end

    // A dropped make still marks the key held so it cannot re-fire until released.
    always_comb begin
        held_d = held_q;
        if (makeEvt) begin
            held_d = held_q | keySel;
        end else if (breakEvt) begin
            held_d = held_q & ~keySel;
        end
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushEn) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (dropEvt) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q     <= 10'd0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            held_q     <= held_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 3'd0;
            end
        end else if (pushEn) begin
            mem_q[wrPtr_q] <= keyCmd;
        end
    end

    always_comb begin
        cmd_valid = (count_q != '0);
        cmd       = cmd_valid ? mem_q[rdPtr_q] : 3'd0;
        held      = held_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_ps2_key_cmd.sv
// Directed bench for ps2_key_cmd: key decode, typematic filter, FIFO order,
// overflow and mid-operation reset, all against hand-computed expectations.
module tb_ps2_key_cmd;

    logic       clk;
    logic       rst;
    logic [9:0] key_data;
    logic       key_valid;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] held;
    logic       overflow;
    logic       clr_overflow;

    int checkCount;
    int errorCount;

    ps2_key_cmd #(.DEPTH(4), .AW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_data     (key_data),
        .key_valid    (key_valid),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .held         (held),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Each stimulus task starts and ends 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [9:0] code);
        key_data  = code;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        key_data  = 10'd0;
    endtask

    task automatic popOne();
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk); #1;
    endtask

    initial begin
        checkCount   = 0;
        errorCount   = 0;
        rst          = 1'b1;
        key_data     = 10'd0;
        key_valid    = 1'b0;
        cmd_ready    = 1'b0;
        clr_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        checkOutput("rst_cmd",       32'(cmd),       32'd0);
        checkOutput("rst_held",      32'(held),      32'd0);
        checkOutput("rst_overflow",  32'(overflow),  32'd0);
        rst = 1'b0;
        idleCycle();

        // Up arrow make, then consume it, then release it.
        applyStimulus(10'h275);
        checkOutput("up_valid", 32'(cmd_valid), 32'd1);
        checkOutput("up_cmd",   32'(cmd),       32'd0);
        checkOutput("up_held",  32'(held),      32'h001);
        popOne();
        checkOutput("up_popped", 32'(cmd_valid), 32'd0);
        applyStimulus(10'h375);
        checkOutput("up_break_held", 32'(held), 32'h000);

        // W typematic: three makes, break, make -> exactly two UP entries.
        applyStimulus(10'h01D);
        applyStimulus(10'h01D);
        applyStimulus(10'h01D);
        applyStimulus(10'h11D);
        applyStimulus(10'h01D);
        checkOutput("w_held", 32'(held), 32'h010);
        checkOutput("w_first_valid", 32'(cmd_valid), 32'd1);
        checkOutput("w_first_cmd",   32'(cmd),       32'd0);
        popOne();
        checkOutput("w_second_valid", 32'(cmd_valid), 32'd1);
        checkOutput("w_second_cmd",   32'(cmd),       32'd0);
        popOne();
        checkOutput("w_drained", 32'(cmd_valid), 32'd0);
        applyStimulus(10'h11D);

        // Keypad 8 (no E0) and Enter are not game keys.
        applyStimulus(10'h075);
        applyStimulus(10'h05A);
        checkOutput("nomatch_held",  32'(held),      32'h000);
        checkOutput("nomatch_valid", 32'(cmd_valid), 32'd0);

        // Five makes into a 4-deep FIFO with no consumer.
        applyStimulus(10'h275);
        applyStimulus(10'h272);
        applyStimulus(10'h26B);
        applyStimulus(10'h274);
        checkOutput("fill_no_ovf", 32'(overflow), 32'd0);
        applyStimulus(10'h02D);
        checkOutput("ovf_set",  32'(overflow), 32'd1);
        checkOutput("ovf_held", 32'(held),     32'h10F);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain_valid%0d", i), 32'(cmd_valid), 32'd1);
            checkOutput($sformatf("drain_cmd%0d", i),   32'(cmd),       32'(i));
            popOne();
        end
        checkOutput("drain_empty", 32'(cmd_valid), 32'd0);
        checkOutput("ovf_sticky",  32'(overflow),  32'd1);
        clr_overflow = 1'b1;
        idleCycle();
        clr_overflow = 1'b0;
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);
        applyStimulus(10'h375);
        applyStimulus(10'h372);
        applyStimulus(10'h36B);
        applyStimulus(10'h374);
        applyStimulus(10'h12D);
        checkOutput("all_released", 32'(held), 32'h000);

        // Full FIFO with a pop and Esc make on the same edge.
        applyStimulus(10'h275);
        applyStimulus(10'h272);
        applyStimulus(10'h26B);
        applyStimulus(10'h274);
        cmd_ready = 1'b1;
        applyStimulus(10'h076);
        cmd_ready = 1'b0;
        checkOutput("fullpop_ovf",  32'(overflow), 32'd0);
        checkOutput("fullpop_held", 32'(held),     32'h20F);
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("fullpop_valid%0d", i), 32'(cmd_valid), 32'd1);
            checkOutput($sformatf("fullpop_cmd%0d", i),   32'(cmd),       32'(i));
            popOne();
        end
        checkOutput("fullpop_empty", 32'(cmd_valid), 32'd0);
        applyStimulus(10'h375);
        applyStimulus(10'h372);
        applyStimulus(10'h36B);
        applyStimulus(10'h374);
        applyStimulus(10'h176);

        // Reset mid-operation with two entries queued and keys held.
        applyStimulus(10'h275);
        applyStimulus(10'h01D);
        checkOutput("prerst_held",  32'(held),      32'h011);
        checkOutput("prerst_valid", 32'(cmd_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(cmd_valid), 32'd0);
        checkOutput("midrst_held",  32'(held),      32'h000);
        checkOutput("midrst_ovf",   32'(overflow),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idleCycle();
        applyStimulus(10'h274);
        checkOutput("postrst_valid", 32'(cmd_valid), 32'd1);
        checkOutput("postrst_cmd",   32'(cmd),       32'd3);
        checkOutput("postrst_held",  32'(held),      32'h008);
        popOne();
        checkOutput("postrst_empty", 32'(cmd_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
